uart_rx_uint32_bcd: RTL

- Serial receiver and decimal parser, the receive-side counterpart of the uint32 BCD transmitter.
- Deserialises 8N1 UART frames using the baud_x4 strobe from uart_clk.
- Accumulates ASCII decimal digits into a packed-BCD word and publishes the word on a CR or LF terminator.
- Sits between serial_rxd and user logic, for example to preload the BCD counter chain or to drive a register.

---
 rtl/uart_rx_uint32_bcd.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_uint32_bcd.sv
// 8N1 UART receiver that accumulates ASCII decimal digits into a packed-BCD word
// and publishes it on a CR or LF terminator.
module uart_rx_uint32_bcd #(
    parameter int unsigned NDIGITS = 8
) (
    input  logic                   mclk,
    input  logic                   reset,
    input  logic                   baud_x4,
    input  logic                   serial,
    output logic [4*NDIGITS-1:0]   data,
    output logic                   data_strobe,
    output logic                   overflow,
    output logic                   rx_error,
    output logic                   busy
);

    localparam int unsigned DW = 4 * NDIGITS;
    localparam int unsigned CW = $clog2(NDIGITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        state, state_next;
    logic [1:0]    phase, phase_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [7:0]    shreg, shreg_next;
    logic          byte_done_c;
    logic          frame_err_c;

    logic          rx_meta, rx_s;
    logic          byte_valid;
    logic [DW-1:0] acc;
    logic [CW-1:0] count;
    logic          ovf_pending;

    logic          is_digit_c;
    logic          is_term_c;

    // Two-flop synchroniser for the asynchronous line; idles high.
    always_ff @(posedge mclk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= serial;
            rx_s    <= rx_meta;
        end
    end

    // Bit FSM state register.
    always_ff @(posedge mclk) begin
        if (reset) begin
            state   <= IDLE;
            phase   <= 2'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
            busy    <= 1'b0;
        end else begin
            state   <= state_next;
            phase   <= phase_next;
            bit_idx <= bit_idx_next;
            shreg   <= shreg_next;
            busy    <= (state_next != IDLE);
        end
    end

    // Next-state logic; every line decision happens on a baud_x4 tick, mid-bit at phase 1->2.
    always_comb begin
        state_next   = state;
        phase_next   = phase;
        bit_idx_next = bit_idx;
        shreg_next   = shreg;
        byte_done_c  = 1'b0;
        frame_err_c  = 1'b0;
        if (baud_x4) begin
            phase_next = phase + 2'd1;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_next = START;
                        phase_next = 2'd0;
                    end
                end
                START: begin
                    if (phase == 2'd1) begin
                        if (!rx_s) begin
                            state_next   = DATA;
                            bit_idx_next = 3'd0;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                DATA: begin
                    if (phase == 2'd1) begin
                        shreg_next = {rx_s, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state_next = STOP;
                        end else begin
                            bit_idx_next = bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (phase == 2'd1) begin
                        if (rx_s) begin
                            state_next  = IDLE;
                            byte_done_c = 1'b1;
                        end else begin
                            state_next  = BREAK;
                            frame_err_c = 1'b1;
                        end
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        is_digit_c = (shreg >= 8'h30) && (shreg <= 8'h39);
        is_term_c  = (shreg == 8'h0D) || (shreg == 8'h0A);
    end

    // Character processing one cycle after a good stop bit; framing errors flush the accumulator.
    always_ff @(posedge mclk) begin
        if (reset) begin
            byte_valid  <= 1'b0;
            acc         <= '0;
            count       <= '0;
            ovf_pending <= 1'b0;
            data        <= '0;
            data_strobe <= 1'b0;
            overflow    <= 1'b0;
            rx_error    <= 1'b0;
        end else begin
            byte_valid  <= byte_done_c;
            data_strobe <= 1'b0;
            rx_error    <= 1'b0;
            if (frame_err_c) begin
                rx_error    <= 1'b1;
                acc         <= '0;
                count       <= '0;
                ovf_pending <= 1'b0;
            end else if (byte_valid) begin
                if (is_digit_c) begin
                    if (count < CW'(NDIGITS)) begin
                        acc   <= {acc[DW-5:0], shreg[3:0]};
                        count <= count + CW'(1);
                    end else begin
                        ovf_pending <= 1'b1;
                    end
                end else if (is_term_c) begin
                    if (count != '0) begin
                        data        <= acc;
                        overflow    <= ovf_pending;
                        data_strobe <= 1'b1;
                        acc         <= '0;
                        count       <= '0;
                        ovf_pending <= 1'b0;
                    end
                end else begin
                    rx_error    <= 1'b1;
                    acc         <= '0;
                    count       <= '0;
                    ovf_pending <= 1'b0;
                end
            end
        end
    end

endmodule
